// File: rtl/bsg_comm_link_calib_seq.sv
// Comm-link calibration sequencer: holds the link in reset, then calibrates
// each channel in turn with bounded retries and a per-attempt timeout.
module bsg_comm_link_calib_seq #(
    parameter int unsigned num_channels_p   = 4,
    parameter int unsigned reset_cycles_p   = 16,
    parameter int unsigned timeout_cycles_p = 1024,
    parameter int unsigned max_retries_p    = 3
) (
    input  logic                      core_clk_i,
    input  logic                      async_reset_n_i,
    input  logic                      start_i,
    output logic [num_channels_p-1:0] ch_calib_v_o,
    input  logic [num_channels_p-1:0] ch_calib_done_i,
    input  logic [num_channels_p-1:0] ch_calib_fail_i,
    output logic                      link_reset_o,
    output logic                      busy_o,
    output logic                      calib_done_o,
    output logic                      calib_error_o,
    output logic [num_channels_p-1:0] good_channels_o
);

    localparam int unsigned idx_w_lp   = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
    localparam int unsigned hold_w_lp  = (reset_cycles_p > 1) ? $clog2(reset_cycles_p) : 1;
    localparam int unsigned tmo_w_lp   = $clog2(timeout_cycles_p);
    localparam int unsigned retry_w_lp = (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1;

    localparam logic [idx_w_lp-1:0]   last_idx_lp  = idx_w_lp'(num_channels_p - 1);
    localparam logic [hold_w_lp-1:0]  hold_last_lp = hold_w_lp'(reset_cycles_p - 1);
    localparam logic [tmo_w_lp-1:0]   tmo_last_lp  = tmo_w_lp'(timeout_cycles_p - 1);
    localparam logic [retry_w_lp-1:0] max_retry_lp = retry_w_lp'(max_retries_p);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e                    state_q,    state_d;
    logic [idx_w_lp-1:0]       idx_q,      idx_d;
    logic [retry_w_lp-1:0]     retry_q,    retry_d;
    logic [hold_w_lp-1:0]      hold_cnt_q, hold_cnt_d;
    logic [tmo_w_lp-1:0]       tmo_cnt_q,  tmo_cnt_d;
    logic [num_channels_p-1:0] good_q,     good_d;

    logic sel_done;
    logic sel_fail;
    logic timeout;
    logic advance;

    // Only the currently selected channel's handshake is observed.
    assign sel_done = ch_calib_done_i[idx_q];
    assign sel_fail = ch_calib_fail_i[idx_q];
    assign timeout  = (tmo_cnt_q == tmo_last_lp);

    always_ff @(posedge core_clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            good_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            good_q     <= good_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        good_d     = good_q;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d    = ST_HOLD;
                    good_d     = '0;
                    idx_d      = '0;
                    retry_d    = '0;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == hold_last_lp) begin
                    state_d = ST_GAP;
                    idx_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + hold_w_lp'(1);
                end
            end
            ST_GAP: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over a simultaneous fail or an expiring timeout.
                if (sel_done) begin
                    good_d[idx_q] = 1'b1;
                    retry_d       = '0;
                    advance       = 1'b1;
                end else if (sel_fail || timeout) begin
                    if (retry_q < max_retry_lp) begin
                        retry_d = retry_q + retry_w_lp'(1);
                        state_d = ST_GAP;
                    end else begin
                        retry_d = '0;
                        advance = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + tmo_w_lp'(1);
                end

                if (advance) begin
                    if (idx_q == last_idx_lp) begin
                        state_d = (good_d != '0) ? ST_DONE : ST_ERROR;
                    end else begin
                        idx_d   = idx_q + idx_w_lp'(1);
                        state_d = ST_GAP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ch_calib_v_o    = '0;
        link_reset_o    = 1'b0;
        busy_o          = 1'b0;
        calib_done_o    = 1'b0;
        calib_error_o   = 1'b0;
        good_channels_o = good_q;

        case (state_q)
            ST_HOLD: begin
                link_reset_o = 1'b1;
                busy_o       = 1'b1;
            end
            ST_GAP: begin
                busy_o = 1'b1;
            end
            ST_WAIT: begin
                busy_o       = 1'b1;
                ch_calib_v_o = num_channels_p'(1) << idx_q;
            end
            ST_DONE: begin
                calib_done_o = 1'b1;
            end
            ST_ERROR: begin
                calib_error_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule
